// File: rtl/ysyx_22050133_rw_responder.sv
// ysyx_22050133_rw_responder
//
// Memory-side responder for the core's rw bus, used both as the simulation
// memory model and as the on-chip SRAM endpoint. One address phase is taken
// in S_IDLE; the responder then sinks len+1 write beats (S_W) or, after
// RD_LATENCY idle cycles (S_RLAT), sources len+1 read beats (S_R). The
// backing store is a synchronous-write, registered-read doubleword array.
// FIXED, INCR and WRAP bursts are supported, and narrow beats use byte masks.
//
// Handshake rule for every channel (rw_addr, w_data, r_data): a transfer
// happens on a rising clk edge where valid and ready are both high. A source
// holding valid keeps its payload stable until that edge. This responder
// never lowers r_data_valid_o before the beat is taken.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   rw_addr_valid_i    request valid
//   rw_addr_ready_o    request accepted (high only in S_IDLE)
//   rw_addr_i          start byte address
//   rw_we_i            1 = write burst, 0 = read burst
//   rw_len_i           beats minus one
//   rw_size_i          log2 bytes per beat (0..3; larger values act as 3)
//   rw_burst_i         0 = FIXED, 1 = INCR, 2 = WRAP (3 acts as INCR)
//   rw_if_i            instruction-fetch tag, only counted
//   w_data_valid_i     write beat valid
//   w_data_ready_o     write beat accepted (high only in S_W)
//   w_data_i           write beat data, right-justified
//   r_data_valid_o     read beat valid
//   r_data_ready_i     read beat accepted
//   r_data_o           read beat data, right-justified and size-masked
//   rw_err_o           one-cycle pulse after a request whose start address
//                      is outside the memory

module ysyx_22050133_rw_responder #(
  parameter int                       RW_DATA_WIDTH  = 64,
  parameter int                       RW_ADDR_WIDTH  = 32,
  parameter logic [RW_ADDR_WIDTH-1:0] MEM_BASE       = 32'h8000_0000,
  parameter int                       MEM_DEPTH_LOG2 = 12,
  parameter int                       RD_LATENCY     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rw_addr_valid_i,
  output logic                     rw_addr_ready_o,
  input  logic [RW_ADDR_WIDTH-1:0] rw_addr_i,
  input  logic                     rw_we_i,
  input  logic [7:0]               rw_len_i,
  input  logic [2:0]               rw_size_i,
  input  logic [1:0]               rw_burst_i,
  input  logic                     rw_if_i,
  input  logic                     w_data_valid_i,
  output logic                     w_data_ready_o,
  input  logic [RW_DATA_WIDTH-1:0] w_data_i,
  output logic                     r_data_valid_o,
  input  logic                     r_data_ready_i,
  output logic [RW_DATA_WIDTH-1:0] r_data_o,
  output logic                     rw_err_o
);

  localparam int         DEPTH       = 1 << MEM_DEPTH_LOG2;
  localparam logic [3:0] LAT         = 4'(RD_LATENCY);
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef logic [RW_ADDR_WIDTH-1:0] addr_t;
  typedef logic [RW_DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RLAT,
    S_R,
    S_W
  } state_t;

  // ---------------------------------------------------------------------
  // Address helpers
  // ---------------------------------------------------------------------
  function automatic logic in_range(input addr_t a);
    // Subtraction wraps, so addresses below MEM_BASE land far above the top.
    return ((a - MEM_BASE) >> (MEM_DEPTH_LOG2 + 3)) == '0;
  endfunction

  function automatic logic [MEM_DEPTH_LOG2-1:0] word_idx(input addr_t a);
    return MEM_DEPTH_LOG2'((a - MEM_BASE) >> 3);
  endfunction

  function automatic data_t size_mask(input logic [1:0] s);
    data_t m;
    case (s)
      2'd0:    m = RW_DATA_WIDTH'(8'hff);
      2'd1:    m = RW_DATA_WIDTH'(16'hffff);
      2'd2:    m = RW_DATA_WIDTH'(32'hffff_ffff);
      default: m = '1;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] byte_mask(input logic [1:0] s);
    logic [7:0] m;
    case (s)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m;
  endfunction

  function automatic addr_t next_addr(input addr_t a, input logic [1:0] s,
                                      input logic [1:0] b, input logic [7:0] l);
    addr_t inc;
    addr_t wrap_mask;
    addr_t res;
    inc       = a + (addr_t'(1) << s);
    wrap_mask = ((addr_t'(l) + addr_t'(1)) << s) - addr_t'(1);
    case (b)
      BURST_FIXED: res = a;
      BURST_WRAP: begin
        // Only power-of-two beat counts wrap; anything else runs as INCR.
        if (l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15)
          res = (a & ~wrap_mask) | (inc & wrap_mask);
        else
          res = inc;
      end
      default: res = inc;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t      state;
  addr_t       cur_addr;
  logic [7:0]  len_q;
  logic [7:0]  beat_cnt;
  logic [1:0]  size_q;
  logic [1:0]  burst_q;
  logic [3:0]  lat_cnt;
  logic [31:0] if_count;

  data_t       mem [0:DEPTH-1];
  data_t       mem_q;

  logic        addr_hs;
  logic        r_hs;
  logic        w_hs;
  logic        last_beat;
  addr_t       nxt_addr;
  addr_t       rd_addr;
  logic [1:0]  size_in;
  logic [5:0]  sh;
  logic [7:0]  wr_be;
  data_t       wr_data;
  logic        mem_we;

  assign addr_hs   = rw_addr_valid_i & rw_addr_ready_o;
  assign r_hs      = r_data_valid_o & r_data_ready_i;
  assign w_hs      = w_data_valid_i & w_data_ready_o;
  assign last_beat = (beat_cnt == len_q);
  assign nxt_addr  = next_addr(cur_addr, size_q, burst_q, len_q);
  assign size_in   = rw_size_i[2] ? 2'd3 : rw_size_i[1:0];
  assign sh        = {cur_addr[2:0], 3'b000};

  // Lanes past byte 7 fall off the shift: unaligned beats that cross the
  // doubleword boundary are truncated rather than split.
  assign wr_be   = byte_mask(size_q) << cur_addr[2:0];
  assign wr_data = w_data_i << sh;
  assign mem_we  = (state == S_W) && w_hs && in_range(cur_addr) && !rst;

  // mem_q must already hold the word of whichever beat is visible next
  // cycle: the request address while idle, the next beat address on a
  // read accept, otherwise the current beat (which also keeps r_data_o
  // stable while the initiator stalls).
  always_comb begin
    rd_addr = cur_addr;
    if (state == S_IDLE)
      rd_addr = rw_addr_i;
    else if (state == S_R && r_hs && !last_beat)
      rd_addr = nxt_addr;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < RW_DATA_WIDTH / 8; b++) begin
        if (wr_be[b])
          mem[word_idx(cur_addr)][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
    mem_q <= mem[word_idx(rd_addr)];
  end

  // Out-of-range beats and idle cycles read as zero.
  assign r_data_o = (r_data_valid_o && in_range(cur_addr)) ?
                    ((mem_q >> sh) & size_mask(size_q)) : '0;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      rw_addr_ready_o <= 1'b1;
      w_data_ready_o  <= 1'b0;
      r_data_valid_o  <= 1'b0;
      rw_err_o        <= 1'b0;
      cur_addr        <= '0;
      len_q           <= 8'd0;
      beat_cnt        <= 8'd0;
      size_q          <= 2'd0;
      burst_q         <= 2'd0;
      lat_cnt         <= 4'd0;
      if_count        <= 32'd0;
    end else begin
      rw_err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (addr_hs) begin
            rw_addr_ready_o <= 1'b0;
            cur_addr        <= rw_addr_i;
            len_q           <= rw_len_i;
            size_q          <= size_in;
            burst_q         <= rw_burst_i;
            beat_cnt        <= 8'd0;
            rw_err_o        <= !in_range(rw_addr_i);
            if (rw_if_i)
              if_count <= if_count + 32'd1;
            if (rw_we_i) begin
              state          <= S_W;
              w_data_ready_o <= 1'b1;
            end else if (LAT == 4'd0) begin
              state          <= S_R;
              r_data_valid_o <= 1'b1;
            end else begin
              state   <= S_RLAT;
              lat_cnt <= LAT;
            end
          end
        end
        S_RLAT: begin
          // Holds for exactly LAT cycles; the counter would hit 0 on the
          // edge that moves to S_R.
          if (lat_cnt == 4'd1) begin
            state          <= S_R;
            r_data_valid_o <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        S_R: begin
          if (r_hs) begin
            if (last_beat) begin
              r_data_valid_o  <= 1'b0;
              rw_addr_ready_o <= 1'b1;
              state           <= S_IDLE;
            end else begin
              cur_addr <= nxt_addr;
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        S_W: begin
          if (w_hs) begin
            if (last_beat) begin
              w_data_ready_o  <= 1'b0;
              rw_addr_ready_o <= 1'b1;
              state           <= S_IDLE;
            end else begin
              cur_addr <= nxt_addr;
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_rw_responder.sv
// Directed testbench for ysyx_22050133_rw_responder. Inputs are driven and
// outputs sampled on the falling clock edge.

module tb_ysyx_22050133_rw_responder;

  localparam int         RD_LAT = 2;
  localparam logic [1:0] FIXED  = 2'd0;
  localparam logic [1:0] INCR   = 2'd1;
  localparam logic [1:0] WRAP   = 2'd2;
  localparam logic [63:0] ONES  = 64'h1111_1111_1111_1111;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        rw_addr_valid_i = 1'b0;
  logic        rw_addr_ready_o;
  logic [31:0] rw_addr_i = '0;
  logic        rw_we_i = 1'b0;
  logic [7:0]  rw_len_i = '0;
  logic [2:0]  rw_size_i = '0;
  logic [1:0]  rw_burst_i = '0;
  logic        rw_if_i = 1'b0;
  logic        w_data_valid_i = 1'b0;
  logic        w_data_ready_o;
  logic [63:0] w_data_i = '0;
  logic        r_data_valid_o;
  logic        r_data_ready_i = 1'b0;
  logic [63:0] r_data_o;
  logic        rw_err_o;

  ysyx_22050133_rw_responder #(
    .RW_DATA_WIDTH (64),
    .RW_ADDR_WIDTH (32),
    .MEM_BASE      (32'h8000_0000),
    .MEM_DEPTH_LOG2(12),
    .RD_LATENCY    (RD_LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rw_addr_valid_i(rw_addr_valid_i),
    .rw_addr_ready_o(rw_addr_ready_o),
    .rw_addr_i      (rw_addr_i),
    .rw_we_i        (rw_we_i),
    .rw_len_i       (rw_len_i),
    .rw_size_i      (rw_size_i),
    .rw_burst_i     (rw_burst_i),
    .rw_if_i        (rw_if_i),
    .w_data_valid_i (w_data_valid_i),
    .w_data_ready_o (w_data_ready_o),
    .w_data_i       (w_data_i),
    .r_data_valid_o (r_data_valid_o),
    .r_data_ready_i (r_data_ready_i),
    .r_data_o       (r_data_o),
    .rw_err_o       (rw_err_o)
  );

  int tests  = 0;
  int failed = 0;

  logic [63:0] wbuf [16];
  logic [63:0] got_q  [$];
  logic [63:0] hold_q [$];
  int          first_wait;
  int          max_gap;

  // -------------------------------------------------------------------
  // Driver tasks (collect only; comparisons live in the test tasks)
  // -------------------------------------------------------------------
  task automatic send_addr(input logic [31:0] a, input logic we, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    int w;
    w = 0;
    while (!rw_addr_ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!rw_addr_ready_o) begin
      tests++;
      failed++;
      $display("FAIL addr_ready_timeout: rw_addr_ready_o=0 want 1 (addr %h)", a);
    end
    rw_addr_valid_i = 1'b1;
    rw_addr_i       = a;
    rw_we_i         = we;
    rw_len_i        = len;
    rw_size_i       = size;
    rw_burst_i      = burst;
    rw_if_i         = 1'($urandom_range(0, 1));
    @(negedge clk);
    rw_addr_valid_i = 1'b0;
  endtask

  task automatic write_beats(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      w_data_i       = wbuf[i];
      w_data_valid_i = 1'b1;
      while (!w_data_ready_o && w < 40) begin
        @(negedge clk);
        w++;
      end
      if (!w_data_ready_o) begin
        tests++;
        failed++;
        $display("FAIL w_ready_timeout beat %0d: w_data_ready_o=0 want 1", i);
        w_data_valid_i = 1'b0;
        return;
      end
      @(negedge clk);
      w_data_valid_i = 1'b0;
      if (i != n - 1)
        repeat (gap) @(negedge clk);
    end
  endtask

  task automatic read_collect(input int n, input logic stall);
    got_q.delete();
    hold_q.delete();
    first_wait     = -1;
    max_gap        = 0;
    r_data_ready_i = !stall;
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      while (!r_data_valid_o && w < 40) begin
        @(negedge clk);
        w++;
      end
      if (!r_data_valid_o) begin
        tests++;
        failed++;
        $display("FAIL r_valid_timeout beat %0d: r_data_valid_o=0 want 1", i);
        r_data_ready_i = 1'b0;
        return;
      end
      if (i == 0) first_wait = w;
      else if (w > max_gap) max_gap = w;
      got_q.push_back(r_data_o);
      if (stall) begin
        repeat (2) @(negedge clk);
        hold_q.push_back(r_data_valid_o ? r_data_o : 64'hdead_dead_dead_dead);
        r_data_ready_i = 1'b1;
      end
      @(negedge clk);
      if (stall) r_data_ready_i = 1'b0;
    end
    r_data_ready_i = 1'b0;
  endtask

  // -------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({rw_addr_ready_o, r_data_valid_o, w_data_ready_o, rw_err_o} !== 4'b1000 ||
          r_data_o !== 64'd0) begin
        failed++;
        $display("FAIL reset_idle cycle %0d: ready/rvalid/wready/err=%b data=%h want 1000 data=0",
                 i, {rw_addr_ready_o, r_data_valid_o, w_data_ready_o, rw_err_o}, r_data_o);
      end
    end
  endtask

  task automatic test_incr;
    for (int i = 0; i < 8; i++) wbuf[i] = ONES * 64'(i + 1);
    send_addr(32'h8000_0040, 1'b1, 8'd7, 3'd3, INCR);
    tests++;
    if ({rw_err_o, w_data_ready_o} !== 2'b01) begin
      failed++;
      $display("FAIL incr_write_start: err/wready=%b want 01", {rw_err_o, w_data_ready_o});
    end
    write_beats(8, 1);
    tests++;
    if ({rw_addr_ready_o, w_data_ready_o} !== 2'b10) begin
      failed++;
      $display("FAIL incr_write_end: ready/wready=%b want 10", {rw_addr_ready_o, w_data_ready_o});
    end

    send_addr(32'h8000_0040, 1'b0, 8'd7, 3'd3, INCR);
    read_collect(8, 1'b0);
    tests++;
    if (first_wait + 1 != RD_LAT + 1) begin
      failed++;
      $display("FAIL read_latency: got %0d cycles want %0d", first_wait + 1, RD_LAT + 1);
    end
    tests++;
    if (max_gap != 0) begin
      failed++;
      $display("FAIL beat_spacing: got gap %0d want 0", max_gap);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (got_q[i] !== ONES * 64'(i + 1)) begin
        failed++;
        $display("FAIL incr_read beat %0d: got %h want %h", i, got_q[i], ONES * 64'(i + 1));
      end
    end

    send_addr(32'h8000_0040, 1'b0, 8'd7, 3'd3, INCR);
    read_collect(8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (got_q[i] !== ONES * 64'(i + 1) || hold_q[i] !== ONES * 64'(i + 1)) begin
        failed++;
        $display("FAIL stall_read beat %0d: got %h held %h want %h",
                 i, got_q[i], hold_q[i], ONES * 64'(i + 1));
      end
    end
  endtask

  task automatic test_narrow;
    wbuf[0] = 64'd0;
    wbuf[1] = 64'd0;
    send_addr(32'h8000_0000, 1'b1, 8'd1, 3'd3, INCR);
    write_beats(2, 0);
    // Upper junk must be masked off by the byte enables.
    wbuf[0] = 64'h1234_5678_9abc_deab;
    send_addr(32'h8000_0003, 1'b1, 8'd0, 3'd0, INCR);
    write_beats(1, 0);

    send_addr(32'h8000_0000, 1'b0, 8'd0, 3'd3, INCR);
    read_collect(1, 1'b0);
    tests++;
    if (got_q[0] !== 64'h0000_0000_ab00_0000) begin
      failed++;
      $display("FAIL narrow_byte_word: got %h want %h", got_q[0], 64'h0000_0000_ab00_0000);
    end

    send_addr(32'h8000_0002, 1'b0, 8'd0, 3'd1, INCR);
    read_collect(1, 1'b0);
    tests++;
    if (got_q[0] !== 64'h0000_0000_0000_ab00) begin
      failed++;
      $display("FAIL narrow_half_read: got %h want %h", got_q[0], 64'h0000_0000_0000_ab00);
    end

    // Word write at byte 6 crosses the lane boundary: only bytes 6,7 land.
    wbuf[0] = 64'h0000_0000_4433_2211;
    send_addr(32'h8000_0006, 1'b1, 8'd0, 3'd2, INCR);
    write_beats(1, 0);
    send_addr(32'h8000_0000, 1'b0, 8'd1, 3'd3, INCR);
    read_collect(2, 1'b0);
    tests++;
    if (got_q[0] !== 64'h2211_0000_ab00_0000 || got_q[1] !== 64'd0) begin
      failed++;
      $display("FAIL narrow_truncate: got %h %h want %h %h",
               got_q[0], got_q[1], 64'h2211_0000_ab00_0000, 64'd0);
    end

    send_addr(32'h8000_0005, 1'b0, 8'd0, 3'd2, INCR);
    read_collect(1, 1'b0);
    tests++;
    if (got_q[0] !== 64'h0000_0000_0022_1100) begin
      failed++;
      $display("FAIL narrow_word_unaligned: got %h want %h", got_q[0], 64'h0000_0000_0022_1100);
    end
  endtask

  task automatic test_bursts;
    logic [63:0] exp_wrap [4];
    exp_wrap[0] = ONES * 64'd3;
    exp_wrap[1] = ONES * 64'd4;
    exp_wrap[2] = ONES * 64'd1;
    exp_wrap[3] = ONES * 64'd2;
    send_addr(32'h8000_0050, 1'b0, 8'd3, 3'd3, WRAP);
    read_collect(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got_q[i] !== exp_wrap[i]) begin
        failed++;
        $display("FAIL wrap_read beat %0d: got %h want %h", i, got_q[i], exp_wrap[i]);
      end
    end

    send_addr(32'h8000_0048, 1'b0, 8'd3, 3'd3, FIXED);
    read_collect(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got_q[i] !== ONES * 64'd2) begin
        failed++;
        $display("FAIL fixed_read beat %0d: got %h want %h", i, got_q[i], ONES * 64'd2);
      end
    end

    // Three beats cannot wrap; the burst runs linearly.
    send_addr(32'h8000_0060, 1'b0, 8'd2, 3'd3, WRAP);
    read_collect(3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (got_q[i] !== ONES * 64'(i + 5)) begin
        failed++;
        $display("FAIL wrap_odd_len beat %0d: got %h want %h", i, got_q[i], ONES * 64'(i + 5));
      end
    end
  endtask

  task automatic test_out_of_range;
    // 0x80001000 shares its low index bits with 0x00001000.
    wbuf[0] = 64'h5a5a_5a5a_5a5a_5a5a;
    send_addr(32'h8000_1000, 1'b1, 8'd0, 3'd3, INCR);
    write_beats(1, 0);

    send_addr(32'h0000_1000, 1'b0, 8'd0, 3'd3, INCR);
    tests++;
    if (rw_err_o !== 1'b1) begin
      failed++;
      $display("FAIL oor_read_err: got %b want 1", rw_err_o);
    end
    @(negedge clk);
    tests++;
    if (rw_err_o !== 1'b0) begin
      failed++;
      $display("FAIL oor_err_pulse_width: got %b want 0", rw_err_o);
    end
    read_collect(1, 1'b0);
    tests++;
    if (got_q[0] !== 64'd0) begin
      failed++;
      $display("FAIL oor_read_data: got %h want 0", got_q[0]);
    end

    send_addr(32'h0000_1000, 1'b1, 8'd0, 3'd3, INCR);
    tests++;
    if (rw_err_o !== 1'b1) begin
      failed++;
      $display("FAIL oor_write_err: got %b want 1", rw_err_o);
    end
    wbuf[0] = 64'hffff_ffff_ffff_ffff;
    write_beats(1, 0);
    send_addr(32'h8000_1000, 1'b0, 8'd0, 3'd3, INCR);
    read_collect(1, 1'b0);
    tests++;
    if (got_q[0] !== 64'h5a5a_5a5a_5a5a_5a5a) begin
      failed++;
      $display("FAIL oor_write_dropped: got %h want %h", got_q[0], 64'h5a5a_5a5a_5a5a_5a5a);
    end
  endtask

  task automatic test_reset_mid_burst;
    for (int i = 0; i < 8; i++) wbuf[i] = 64'ha5a5_a5a5_0000_0000 | 64'(i);
    send_addr(32'h8000_0080, 1'b1, 8'd7, 3'd3, INCR);
    write_beats(8, 0);

    for (int i = 0; i < 8; i++) wbuf[i] = 64'h0f0f_0f0f_0000_0000 | 64'(i);
    send_addr(32'h8000_0080, 1'b1, 8'd7, 3'd3, INCR);
    write_beats(3, 0);
    w_data_i       = wbuf[3];
    w_data_valid_i = 1'b1;
    rst            = 1'b1;
    @(negedge clk);
    rst            = 1'b0;
    w_data_valid_i = 1'b0;
    tests++;
    if ({rw_addr_ready_o, r_data_valid_o, w_data_ready_o} !== 3'b100) begin
      failed++;
      $display("FAIL reset_abort: ready/rvalid/wready=%b want 100",
               {rw_addr_ready_o, r_data_valid_o, w_data_ready_o});
    end

    send_addr(32'h8000_0080, 1'b0, 8'd7, 3'd3, INCR);
    read_collect(8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [63:0] exp;
      exp = (i < 3) ? (64'h0f0f_0f0f_0000_0000 | 64'(i)) : (64'ha5a5_a5a5_0000_0000 | 64'(i));
      tests++;
      if (got_q[i] !== exp) begin
        failed++;
        $display("FAIL reset_commit beat %0d: got %h want %h", i, got_q[i], exp);
      end
    end
  endtask

  // -------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------
  initial begin
    test_reset();
    test_incr();
    test_narrow();
    test_bursts();
    test_out_of_range();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_22050133_rw_responder.md
Name: ysyx_22050133_rw_responder

Overview:
Memory-side responder for the core's simplified AXI-like rw bus, as driven by the cache refill/writeback path and the uncached load/store path. It accepts one address phase, then sinks len+1 write beats or sources len+1 read beats from an internal synchronous-write doubleword array. It serves as the simulation memory model and as the on-chip SRAM endpoint. Burst types FIXED, INCR and WRAP are supported, and narrow accesses use byte masking.

Parameters:
RW_DATA_WIDTH, 64, beat width in bits; fixed at 64.
RW_ADDR_WIDTH, 32, address width.
MEM_BASE, 32'h80000000, byte address of word 0.
MEM_DEPTH_LOG2, 12, log2 of the number of 64-bit words.
RD_LATENCY, 2, idle cycles between the address handshake and the first read beat; valid range 0..15.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rw_addr_valid_i  in  1  request valid
rw_addr_ready_o  out  1  request accepted
rw_addr_i  in  RW_ADDR_WIDTH  start byte address
rw_we_i  in  1  1 = write burst, 0 = read burst
rw_len_i  in  8  beats minus 1
rw_size_i  in  3  bytes per beat: 0=1, 1=2, 2=4, 3=8
rw_burst_i  in  2  0=FIXED, 1=INCR, 2=WRAP
rw_if_i  in  1  instruction-fetch tag; no functional effect; counted only
w_data_valid_i  in  1  write beat valid
w_data_ready_o  out  1  write beat accepted
w_data_i  in  RW_DATA_WIDTH  write beat data, right-justified
r_data_valid_o  out  1  read beat valid
r_data_ready_i  in  1  read beat accepted
r_data_o  out  RW_DATA_WIDTH  read beat data, right-justified and masked to size
rw_err_o  out  1  one-cycle pulse: request hit outside the memory range

Behaviour:
- Clocking: single clock domain; clk rising edge. rst is synchronous and active-high.
- Reset values: rw_addr_ready_o=1, w_data_ready_o=0, r_data_valid_o=0, r_data_o=0, rw_err_o=0, state=S_IDLE. Memory array is not reset.
- Reset mid-burst aborts the burst. Writes already committed persist.
- States:
  - S_IDLE: ready=1. On valid&ready, latch addr, we, len, size, burst and beat count; drop ready the next cycle. If we=1 go to S_W. If we=0 go to S_RLAT with counter=RD_LATENCY, or straight to S_R if RD_LATENCY=0.
  - S_RLAT: count down each cycle; on reaching 0, enter S_R.
  - S_R: r_data_valid_o=1 with the current beat's data. On valid&ready: if beats remain, advance the address and present the next beat the following cycle with valid kept high. On the last beat, drop valid and go to S_IDLE with ready=1.
  - S_W: w_data_ready_o=1. Each w valid&ready commits one beat at the current address. The last beat (count==len) returns to S_IDLE. Beats may arrive non-consecutively, e.g. every other cycle.
- Initiator ready dropping: the initiator may deassert r_data_ready_i between beats. The responder holds r_data_o stable while valid&~ready.
- Beat address:
  - FIXED: constant.
  - INCR: +2^size per beat.
  - WRAP: +2^size, wrapping within the aligned block of (len+1)<<size bytes; len must be 1, 3, 7 or 15, otherwise treated as INCR.
- Read data: the doubleword at word index (addr-MEM_BASE)>>3, shifted right by addr[2:0]*8, ANDed with the size mask (0xff, 0xffff, 0xffffffff, all-ones). Data comes from a registered array read, so the responder must fetch the next word in advance to keep beat-to-beat spacing at 1 cycle.
- Write data: w_data_i shifted left by addr[2:0]*8. Byte enables = size mask shifted by addr[2:0], truncated to 8 lanes.
- Unaligned narrow accesses that cross the 8-byte lane boundary are truncated; there is no error.
- Range: addresses are checked per beat. An out-of-range read beat returns 0; an out-of-range write beat is dropped. rw_err_o pulses once, in the cycle after an address handshake whose start address is out of range.
- Simultaneous events: in S_IDLE, w_data_valid_i is ignored (no write-data-before-address support). A new request is never accepted in the same cycle as the last beat; ready rises the cycle after.

Test Plan:
- Reset, then idle for 5 cycles: rw_addr_ready_o=1, r_data_valid_o=0, w_data_ready_o=0, rw_err_o=0 throughout.
- INCR write: addr 0x80000040, len 7, size 3, data 0x1111..1..0x8888..8, w valid every other cycle. Then INCR read of the same block → 8 beats in order. First valid appears RD_LATENCY+1 cycles after the address handshake. Initiator drops ready between beats; each beat is held stable.
- Narrow write: size 0, addr 0x80000003, data 0xAB. Then size 3 read at 0x80000000 → only byte 3 changed (0x00000000AB000000 over a zeroed word). Size 1 read at 0x80000002 → 0xAB00.
- WRAP read: addr 0x80000050, len 3, size 3 → beat addresses 0x50, 0x58, 0x40, 0x48. FIXED read: len 3 → same word returned 4 times.
- Out-of-range: read at 0x00001000, len 0 → rw_err_o pulses once, r_data_o=0. Write at the same address → memory unchanged.
- Reset asserted during beat 3 of an 8-beat write: next cycle rw_addr_ready_o=1 and r_data_valid_o=0. Beats 0-2 are committed; beats 3-7 are unchanged.
